// File: rtl/sdram_rom_loader.sv
// rtl/sdram_rom_loader.sv - packs an upload byte stream into 16-bit SDRAM writes on a 4-phase handshake
// Optional build macro: LOADER_BYTESWAP_EN (first byte of each pair goes to the low half).
module sdram_rom_loader #(
  parameter logic [7:0] PAD_BYTE    = 8'hFF,
  parameter int         ACK_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [31:0] byte_count,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        writeport_wr,
  output logic [31:0] writeport_addr,
  output logic [15:0] writeport_data,
  input  logic        writeport_ack,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] words_written
);

  typedef enum logic [2:0] {IDLE, B0, B1, REQ, REL, DONE, ERR} state_t;

  state_t      state, state_next;
  logic [31:0] addr_q, remaining, words_q, tmo_cnt;
  logic [15:0] data_q;
  logic        accept, timeout, enter_hs;

  assign accept   = in_valid && in_ready;
  assign timeout  = (ACK_TIMEOUT != 0) && (tmo_cnt == 32'(ACK_TIMEOUT - 1));
  assign enter_hs = (state_next != state) && (state_next == REQ || state_next == REL);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_next = (byte_count == 32'd0) ? DONE : B0;
      B0:  if (accept) state_next = (remaining == 32'd1) ? REQ : B1;
      B1:  if (accept) state_next = REQ;
      REQ: begin
        if (writeport_ack) state_next = REL;
        else if (timeout)  state_next = ERR;
      end
      REL: begin
        if (!writeport_ack)  state_next = (remaining <= 32'd2) ? DONE : B0;
        else if (timeout)    state_next = ERR;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the state register only, so they change solely on clock edges.
  always_comb begin
    in_ready     = 1'b0;
    writeport_wr = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    error        = 1'b0;
    case (state)
      IDLE:    busy = 1'b0;
      B0, B1:  in_ready = 1'b1;
      REQ:     writeport_wr = 1'b1;
      DONE:    begin busy = 1'b0; done = 1'b1; end
      ERR:     begin busy = 1'b0; error = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q    <= 32'd0;
      data_q    <= 16'd0;
      remaining <= 32'd0;
      words_q   <= 32'd0;
      tmo_cnt   <= 32'd0;
    end else begin
      if (enter_hs)                       tmo_cnt <= 32'd0;
      else if (state == REQ || state == REL) tmo_cnt <= tmo_cnt + 32'd1;

      case (state)
        IDLE, DONE, ERR: if (start) begin
          addr_q    <= base_addr;
          remaining <= byte_count;
          words_q   <= 32'd0;
        end
        B0: if (accept) begin
`ifdef LOADER_BYTESWAP_EN
          data_q[7:0] <= in_data;
          if (remaining == 32'd1) data_q[15:8] <= PAD_BYTE;
`else
          data_q[15:8] <= in_data;
          if (remaining == 32'd1) data_q[7:0] <= PAD_BYTE;
`endif
        end
        B1: if (accept) begin
`ifdef LOADER_BYTESWAP_EN
          data_q[15:8] <= in_data;
`else
          data_q[7:0] <= in_data;
`endif
        end
        REL: if (!writeport_ack) begin
          addr_q    <= addr_q + 32'd1;
          words_q   <= words_q + 32'd1;
          remaining <= remaining - ((remaining >= 32'd2) ? 32'd2 : remaining);
        end
        default: ;
      endcase
    end
  end

  assign writeport_addr = addr_q;
  assign writeport_data = data_q;
  assign words_written  = words_q;

endmodule
